jtag_tap_master: RTL and testbench

//  Host-side JTAG initiator: drives TCK/TMS/TDI into a TAP (e.g. a Nios II debug TAP) and samples TDO.

---
 rtl/jtag_master_pkg.sv | 37 +++
 rtl/jtag_tck_gen.sv | 54 +++++
 rtl/jtag_tap_master.sv | 197 +++++++++++++++++++
 tb/tb_jtag_tap_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// Shared types and TMS sequence constants for the JTAG TAP master.
// TMS preambles are stored LSB-first, so bit 0 is the first TMS value driven.
package jtag_master_pkg;

  typedef enum logic [1:0] {
    OP_TLR_RESET   = 2'b00,
    OP_SCAN_IR     = 2'b01,
    OP_SCAN_DR     = 2'b10,
    OP_IDLE_CLOCKS = 2'b11
  } jtag_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TLR,
    ST_TO_RTI,
    ST_SEL,
    ST_SHIFT,
    ST_EXIT_UPD,
    ST_RTI_CNT,
    ST_DONE,
    ST_RESP
  } jtag_state_e;

  // RTI -> Shift-IR: 1,1,0,0   RTI -> Shift-DR: 1,0,0
  localparam logic [3:0] IR_PREAMBLE = 4'b0011;
  localparam int         IR_PRE_LEN  = 4;
  localparam logic [2:0] DR_PREAMBLE = 3'b001;
  localparam int         DR_PRE_LEN  = 3;
  localparam int         TLR_LEN     = 5;

  function automatic logic preamble_bit(input jtag_op_e op, input logic [1:0] idx);
    logic [3:0] pre;
    pre = (op == OP_SCAN_IR) ? IR_PREAMBLE : {1'b0, DR_PREAMBLE};
    return pre[idx];
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: one strobe every CLK_DIV clk while enabled, alternating fall then rise.
// Disabled state parks tck low so the next enable starts with a fall strobe.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int             DW       = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;
  logic          tck_q, tck_d;

  assign fall_stb = en && (div_q == '0) && !phase_q;
  assign rise_stb = en && (div_q == '0) && phase_q;
  assign tck      = tck_q;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    tck_d   = tck_q;
    if (!en) begin
      div_d   = '0;
      phase_d = 1'b0;
      tck_d   = 1'b0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (fall_stb || rise_stb) begin
        phase_d = ~phase_q;
        tck_d   = phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      tck_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      tck_q   <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_tap_master.sv
// Host-side JTAG initiator: runs TLR/IR/DR/idle sequences on TCK/TMS/TDI and returns TDO.
// Each FSM state describes the TMS/TDI value to drive on the next TCK fall strobe.
module jtag_tap_master
  import jtag_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int            CW        = $clog2(MAX_LEN + 1);
  localparam int            IW        = $clog2(MAX_LEN);
  localparam logic [CW-1:0] TLR_LAST  = CW'(TLR_LEN - 1);
  localparam logic [CW-1:0] IR_LAST   = CW'(IR_PRE_LEN - 1);
  localparam logic [CW-1:0] DR_LAST   = CW'(DR_PRE_LEN - 1);
  localparam logic [6:0]    LEN_CLAMP = 7'(MAX_LEN);

  jtag_state_e        state_q, state_d;
  jtag_op_e           op_q, op_d;
  logic [CW-1:0]      len_q, len_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               synced_q, synced_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cap_en_q, cap_en_d;

  logic               fall_stb, rise_stb, tck_en;
  logic [6:0]         len_clamped;
  logic [CW-1:0]      len_m1;
  logic               shift_last;

  assign tck_en      = (state_q != ST_IDLE) && (state_q != ST_RESP);
  assign len_clamped = (cmd_len > LEN_CLAMP) ? LEN_CLAMP : cmd_len;
  assign len_m1      = len_q - 1'b1;
  assign shift_last  = (cnt_q == len_m1);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (tck_en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    synced_d   = synced_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    cap_en_d   = cap_en_q;

    // TDO enters at the top of the scan window so bit 0 ends up as the first sample
    if (rise_stb && cap_en_q) begin
      cap_d                   = cap_q >> 1;
      cap_d[len_m1[IW-1:0]]   = tdo;
    end
    if (fall_stb) begin
      cap_en_d = 1'b0;
      tdi_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = jtag_op_e'(cmd_op);
          len_d      = CW'(len_clamped);
          cnt_d      = '0;
          sh_d       = cmd_data;
          cap_d      = '0;
          rsp_data_d = '0;
          if (op_d == OP_TLR_RESET)          state_d = ST_TLR;
          else if (len_clamped == 7'd0)      state_d = ST_RESP;
          else if (op_d == OP_IDLE_CLOCKS)   state_d = ST_RTI_CNT;
          else if (!synced_q)                state_d = ST_TLR;
          else                               state_d = ST_SEL;
        end
      end
      ST_TLR: if (fall_stb) begin
        tms_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TLR_LAST) begin
          cnt_d   = '0;
          state_d = ST_TO_RTI;
        end
      end
      ST_TO_RTI: if (fall_stb) begin
        tms_d    = 1'b0;
        synced_d = 1'b1;
        state_d  = (op_q == OP_TLR_RESET) ? ST_DONE : ST_SEL;
      end
      ST_SEL: if (fall_stb) begin
        tms_d = preamble_bit(op_q, cnt_q[1:0]);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ((op_q == OP_SCAN_IR) ? IR_LAST : DR_LAST)) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: if (fall_stb) begin
        tdi_d    = sh_q[0];
        sh_d     = sh_q >> 1;
        tms_d    = shift_last;
        cap_en_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (shift_last) begin
          cnt_d   = '0;
          state_d = ST_EXIT_UPD;
        end
      end
      ST_EXIT_UPD: if (fall_stb) begin
        tms_d = (cnt_q == '0);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_RTI_CNT: if (fall_stb) begin
        tms_d = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == len_m1) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      // Final fall strobe returns tck low; response follows on the next clk
      ST_DONE: if (fall_stb) begin
        tms_d      = 1'b0;
        rsp_data_d = cap_q;
        state_d    = ST_RESP;
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_TLR_RESET;
      len_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      synced_q   <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      cap_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
      synced_q   <= synced_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      cap_en_q   <= cap_en_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign busy      = tck_en;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master against a behavioural IEEE 1149.1 TAP model.
// The model has a 10-bit IR (capture 0x001) and a 64-bit DR, or a TDI->TDO loopback.
module tb_jtag_tap_master;
  import jtag_master_pkg::*;

  localparam int MAX_LEN = 64;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [6:0]         cmd_len = 7'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy, tck, tms, tdi, tdo;

  always #5 clk = ~clk;

  jtag_tap_master #(.CLK_DIV(2), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PAU_DR, T_EX2_DR, T_UPD_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PAU_IR, T_EX2_IR, T_UPD_IR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      T_TLR:    return m ? T_TLR    : T_RTI;
      T_RTI:    return m ? T_SEL_DR : T_RTI;
      T_SEL_DR: return m ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: return m ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  return m ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: return m ? T_UPD_DR : T_PAU_DR;
      T_PAU_DR: return m ? T_EX2_DR : T_PAU_DR;
      T_EX2_DR: return m ? T_UPD_DR : T_SH_DR;
      T_UPD_DR: return m ? T_SEL_DR : T_RTI;
      T_SEL_IR: return m ? T_TLR    : T_CAP_IR;
      T_CAP_IR: return m ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  return m ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: return m ? T_UPD_IR : T_PAU_IR;
      T_PAU_IR: return m ? T_EX2_IR : T_PAU_IR;
      T_EX2_IR: return m ? T_UPD_IR : T_SH_IR;
      default:  return m ? T_SEL_DR : T_RTI;
    endcase
  endfunction

  tap_e         tap = T_SH_DR;
  logic [9:0]   ir_sr = '0, ir_q = '0;
  logic [63:0]  dr_sr = '0, dr_q = '0;
  logic [63:0]  dr_cap = 64'h0123_4567_89AB_CDEF;
  logic         loopback = 1'b0;
  int           tck_cnt = 0;
  logic [127:0] tms_hist = '0;

  assign tdo = loopback ? tdi : ((tap == T_SH_IR) ? ir_sr[0] : dr_sr[0]);

  always @(posedge tck) begin
    case (tap)
      T_CAP_IR: ir_sr <= 10'h001;
      T_SH_IR:  ir_sr <= {tdi, ir_sr[9:1]};
      T_UPD_IR: ir_q  <= ir_sr;
      T_CAP_DR: dr_sr <= dr_cap;
      T_SH_DR:  dr_sr <= {tdi, dr_sr[63:1]};
      T_UPD_DR: dr_q  <= dr_sr;
      default: ;
    endcase
    tap      <= tap_next(tap, tms);
    tck_cnt  <= tck_cnt + 1;
    tms_hist <= {tms_hist[126:0], tms};
  end

  int          n_checks = 0;
  int          n_pass = 0;
  int          tck_base = 0;
  logic [63:0] r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
    int i;
    i = 0;
    @(negedge clk);
    while (!cmd_ready && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tck_base  = tck_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic [63:0] rdata);
    int i;
    int held_cnt;
    i = 0;
    while (!rsp_valid && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("rsp_valid", rsp_valid, 1);
    rdata    = rsp_data;
    held_cnt = tck_cnt;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    if (hold > 0) check("hold_no_tck", tck_cnt, held_cnt);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_done_ready", {rsp_valid, cmd_ready}, 2'b01);
    $display("cmd op=%0d len=%0d data=0x%0h -> rsp=0x%0h tck=%0d", cmd_op, cmd_len, cmd_data,
             rdata, tck_cnt - tck_base);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Unsynced DR scan through loopback: TLR prefix, then 3 + 8 + 2
    loopback = 1'b1;
    start_cmd(OP_SCAN_DR, 7'd8, 64'hA5);
    wait_rsp(0, r);
    check("dr8_data", r, 64'hA5);
    check("dr8_tck", tck_cnt - tck_base, 19);
    check("dr8_tms", tms_hist[18:0], 19'b111110_100_00000001_10);
    check("dr8_tap_rti", tap, T_RTI);
    check("dr8_idle_tck", tck, 0);
    check("dr8_idle_busy", busy, 0);
    loopback = 1'b0;

    start_cmd(OP_TLR_RESET, 7'd0, 64'h0);
    wait_rsp(0, r);
    check("tlr_data", r, 0);
    check("tlr_tck", tck_cnt - tck_base, 6);
    check("tlr_tms", tms_hist[5:0], 6'b111110);
    check("tlr_tap_rti", tap, T_RTI);

    start_cmd(OP_SCAN_IR, 7'd10, 64'h2AA);
    wait_rsp(0, r);
    check("ir10_data", r, 64'h001);
    check("ir10_model_ir", ir_q, 10'h2AA);
    check("ir10_tck", tck_cnt - tck_base, 16);
    check("ir10_tms", tms_hist[15:0], 16'b1100_0000000001_10);
    check("ir10_tap_rti", tap, T_RTI);

    start_cmd(OP_SCAN_DR, 7'd64, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_rsp(20, r);
    check("dr64_data", r, 64'h0123_4567_89AB_CDEF);
    check("dr64_model_dr", dr_q, 64'hFFFF_FFFF_FFFF_FFFF);
    check("dr64_tck", tck_cnt - tck_base, 69);

    start_cmd(OP_IDLE_CLOCKS, 7'd0, 64'h0);
    check("idle0_rsp_next_clk", rsp_valid, 1);
    wait_rsp(0, r);
    check("idle0_data", r, 0);
    check("idle0_tck", tck_cnt - tck_base, 0);

    start_cmd(OP_IDLE_CLOCKS, 7'd3, 64'h0);
    wait_rsp(0, r);
    check("idle3_data", r, 0);
    check("idle3_tck", tck_cnt - tck_base, 3);
    check("idle3_tms", tms_hist[2:0], 3'b000);
    check("idle3_tap_rti", tap, T_RTI);

    start_cmd(OP_IDLE_CLOCKS, 7'd100, 64'h0);
    wait_rsp(0, r);
    check("idle_clamp_tck", tck_cnt - tck_base, 64);

    // Abort a long DR scan partway through the shift phase
    start_cmd(OP_SCAN_DR, 7'd64, 64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < 2000 && (tck_cnt - tck_base) < 10; i++) @(posedge clk);
    check("abort_reached_shift", (tck_cnt - tck_base) >= 10, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tck", tck, 0);
    check("abort_tms", tms, 1);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_rsp", rsp_valid, 0);
    $display("abort: reset mid-shift, rsp_valid=%0d tck=%0d", rsp_valid, tck);

    start_cmd(OP_SCAN_DR, 7'd8, 64'h3C);
    wait_rsp(0, r);
    check("resync_data", r, 64'hEF);
    check("resync_tck", tck_cnt - tck_base, 19);
    check("resync_tms_prefix", tms_hist[18:13], 6'b111110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
